// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
// Read latency and skid depth used by the issue-credit logic.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int RD_LATENCY = 1;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry skid FIFO for BRAM read returns ({last, data}).
// Push on read return, pop on stream handshake; exports occupancy.
module bram_rd_skid
  import bram_stream_reader_pkg::*;
#(
  parameter int B = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [B:0] din,
  input  logic       pop,
  output logic [B:0] head,
  output logic       valid,
  output logic [1:0] occ
);

  logic [B:0] mem [SKID_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (cnt != 2'd0);
  assign occ   = cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// BRAM port-B reader emitting LEN words as an AXI4-Stream master.
// Optional BRAM_STREAM_READER_LOOP_EN adds a loop input for repeating passes.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int N = 16,
  parameter int B = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] start_addr,
  input  logic [N:0]   len,
`ifdef BRAM_STREAM_READER_LOOP_EN
  input  logic         loop,
`endif
  output logic         busy,
  output logic         done,
  output logic         enb,
  output logic [N-1:0] addrb,
  input  logic [B-1:0] dob,
  output logic [B-1:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast
);

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] addr_q;
  logic [N:0]   rem_q;
  logic         pend;
  logic         pend_last;
  logic         issue;
  logic         issue_last;
  logic         start_ok;
  logic         loop_now;
  logic         pop;
  logic         credit;
  logic         final_beat;
  logic [2:0]   fill;
  logic [N-1:0] addr_now;
  logic [N:0]   rem_now;
  logic [N-1:0] addr_nx;
  logic [N:0]   rem_nx;
  logic [B:0]   head;
  logic         head_vld;
  logic [1:0]   occ;

`ifdef BRAM_STREAM_READER_LOOP_EN
  logic [N-1:0] base_q;
  logic [N:0]   len_q;
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign start_ok = (state == IDLE) && start && (len != '0);
  assign addr_now = (state == IDLE) ? start_addr : addr_q;
  assign rem_now  = (state == IDLE) ? len : rem_q;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign fill     = 3'(occ) + 3'(pend) - 3'(pop);
  assign credit   = (fill < 3'(SKID_DEPTH));
  assign issue_last = issue && (rem_now == (N+1)'(1));
  assign final_beat = pop && head[B] && (occ == 2'd1) && !pend;
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          if (issue_last && !loop_now) state_nx = DRAIN;
          else                         state_nx = RUN;
        end
      end
      RUN: begin
        if (issue_last && !loop_now) state_nx = DRAIN;
      end
      DRAIN: begin
        if (final_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read issue: start issues at once, RUN issues while credit remains
  always_comb begin
    issue = 1'b0;
    unique case (state)
      IDLE:    issue = start_ok;
      RUN:     issue = credit && (rem_q != '0);
      default: issue = 1'b0;
    endcase
    enb   = issue;
    addrb = start_ok ? start_addr : addr_q;
  end

  // Next address/count, reloading the pass when looping
  always_comb begin
    addr_nx = addr_now + N'(1);
    rem_nx  = rem_now - (N+1)'(1);
`ifdef BRAM_STREAM_READER_LOOP_EN
    if (issue_last && loop_now) begin
      addr_nx = (state == IDLE) ? start_addr : base_q;
      rem_nx  = (state == IDLE) ? len : len_q;
    end
`endif
  end

  // Address/count progress, in-flight tracking and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (issue) begin
        addr_q <= addr_nx;
        rem_q  <= rem_nx;
      end
      pend      <= issue;
      pend_last <= issue_last;
      done      <= ((state == IDLE) && start && (len == '0))
                || ((state == DRAIN) && final_beat);
    end
  end

`ifdef BRAM_STREAM_READER_LOOP_EN
  // Pass origin kept for loop reloads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (start_ok) begin
      base_q <= start_addr;
      len_q  <= len;
    end
  end
`endif

  bram_rd_skid #(
    .B(B)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (pend),
    .din  ({pend_last, dob}),
    .pop  (pop),
    .head (head),
    .valid(head_vld),
    .occ  (occ)
  );

  assign m_axis_tdata  = head[B-1:0];
  assign m_axis_tvalid = head_vld;
  assign m_axis_tlast  = head_vld && head[B];

endmodule
